// File: rtl/dsi_pkg.sv
// Shared types and helpers for the DSI packet assembler: FSM states, data types,
// the header ECC and the per-byte CRC16 step.
package dsi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        PAYLOAD,
        TAIL
    } state_t;

    localparam logic [5:0]  DT_DCS_SHORT_WR0 = 6'h05;
    localparam logic [5:0]  DT_DCS_LONG_WR   = 6'h39;
    localparam logic [15:0] CRC_INIT         = 16'hFFFF;
    localparam logic [15:0] CRC_POLY_REFL    = 16'h8408;

    // Each parity bit is the XOR of the header bits selected by its mask.
    function automatic logic [7:0] dsi_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return {2'b00, p};
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/dsi_crc16.sv
// Running CRC-16-CCITT over a packet's payload; crc_next_o folds in the strobed
// bytes of the word being loaded so that word can carry the finished checksum.
module dsi_crc16
    import dsi_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  strb_i,
    output logic [15:0] crc_o,
    output logic [15:0] crc_next_o
);

    logic [15:0] crc_q;

    always_comb begin
        crc_next_o = crc_q;
        for (int i = 0; i < 4; i++) begin
            if (strb_i[i]) begin
                crc_next_o = crc16_byte(crc_next_o, data_i[8*i +: 8]);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crc_q <= CRC_INIT;
        end else if (init_i) begin
            crc_q <= CRC_INIT;
        end else if (en_i) begin
            crc_q <= crc_next_o;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/dsi_packet_assembler.sv
// Turns scheduler packet requests into the 32-bit header/payload/CRC word stream
// consumed by the lanes controller, one word per iface_data_rqst.
module dsi_packet_assembler
    import dsi_pkg::*;
#(
    parameter bit          CRC_EN = 1'b1,
    parameter logic [15:0] WC_MAX = 16'hFFFF
) (
    input  logic        clk_sys_i,
    input  logic        rst_i,
    input  logic        pkt_valid_i,
    output logic        pkt_ready_o,
    input  logic        pkt_long_i,
    input  logic [1:0]  pkt_vc_i,
    input  logic [5:0]  pkt_data_type_i,
    input  logic [15:0] pkt_wc_i,
    input  logic [31:0] pld_data_i,
    input  logic        pld_valid_i,
    output logic        pld_ready_o,
    output logic [31:0] iface_write_data_o,
    output logic [3:0]  iface_write_strb_o,
    output logic        iface_write_rqst_o,
    output logic        iface_last_word_o,
    input  logic        iface_data_rqst_i,
    output logic        err_underflow_o,
    output logic        err_wc_o
);

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  strb_q, strb_d;
    logic        rqst_q, rqst_d;
    logic        last_q, last_d;
    logic [15:0] bytes_q, bytes_d;
    logic        rem3_q, rem3_d;
    logic        errUnder_q, errUnder_d;
    logic        errWc_q, errWc_d;

    logic        crcInit, crcEn;
    logic [15:0] crcReg, crcRegNext, crcNow, crcNext;
    logic [2:0]  nBytes;
    logic [3:0]  payStrb;
    logic [31:0] payData;
    logic        wcTooBig;
    logic [15:0] wcHdr;
    logic [23:0] hdr;

    dsi_crc16 u_crc (
        .clk_i      (clk_sys_i),
        .rst_i      (rst_i),
        .init_i     (crcInit),
        .en_i       (crcEn),
        .data_i     (payData),
        .strb_i     (payStrb),
        .crc_o      (crcReg),
        .crc_next_o (crcRegNext)
    );

    // Payload slicing: up to four bytes per word, a missing word is replaced by zeros.
    always_comb begin
        nBytes   = (bytes_q >= 16'd4) ? 3'd4 : bytes_q[2:0];
        case (nBytes)
            3'd1:    payStrb = 4'b0001;
            3'd2:    payStrb = 4'b0011;
            3'd3:    payStrb = 4'b0111;
            default: payStrb = 4'b1111;
        endcase
        payData  = pld_valid_i ? pld_data_i : 32'h0;
        crcNow   = CRC_EN ? crcReg : 16'h0000;
        crcNext  = CRC_EN ? crcRegNext : 16'h0000;
        wcTooBig = pkt_long_i && (pkt_wc_i > WC_MAX);
        wcHdr    = wcTooBig ? WC_MAX : pkt_wc_i;
        hdr      = {wcHdr, pkt_vc_i, pkt_data_type_i};
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        strb_d      = strb_q;
        rqst_d      = 1'b0;
        last_d      = last_q;
        bytes_d     = bytes_q;
        rem3_d      = rem3_q;
        errUnder_d  = errUnder_q;
        errWc_d     = errWc_q;
        crcInit     = 1'b0;
        crcEn       = 1'b0;
        pld_ready_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (pkt_valid_i && ready_q) begin
                    state_d = HEAD;
                    data_d  = {dsi_ecc(hdr), hdr};
                    strb_d  = 4'hF;
                    rqst_d  = 1'b1;
                    last_d  = ~pkt_long_i;
                    bytes_d = pkt_long_i ? wcHdr : 16'd0;
                    rem3_d  = 1'b0;
                    crcInit = 1'b1;
                    if (wcTooBig) errWc_d = 1'b1;
                end
            end
            default: begin
                if (iface_data_rqst_i) begin
                    if (last_q) begin
                        state_d = IDLE;
                        data_d  = 32'h0;
                        strb_d  = 4'h0;
                        last_d  = 1'b0;
                        bytes_d = 16'd0;
                        rem3_d  = 1'b0;
                    end else if (state_q == TAIL) begin
                        last_d = 1'b1;
                        if (rem3_q) begin
                            data_d = {24'h0, crcNow[15:8]};
                            strb_d = 4'b0001;
                        end else begin
                            data_d = {16'h0, crcNow};
                            strb_d = 4'b0011;
                        end
                    end else if (bytes_q == 16'd0) begin
                        state_d = TAIL;
                        data_d  = {16'h0, crcNow};
                        strb_d  = 4'b0011;
                        last_d  = 1'b1;
                    end else begin
                        // Payload load: the CRC bytes ride in the same word when room allows.
                        pld_ready_o = 1'b1;
                        crcEn       = 1'b1;
                        if (!pld_valid_i) errUnder_d = 1'b1;
                        bytes_d = bytes_q - {13'd0, nBytes};
                        state_d = PAYLOAD;
                        case (nBytes)
                            3'd1: begin
                                data_d = {8'h0, crcNext, payData[7:0]};
                                strb_d = 4'b0111;
                                last_d = 1'b1;
                            end
                            3'd2: begin
                                data_d = {crcNext, payData[15:0]};
                                strb_d = 4'b1111;
                                last_d = 1'b1;
                            end
                            3'd3: begin
                                data_d  = {crcNext[7:0], payData[23:0]};
                                strb_d  = 4'b1111;
                                rem3_d  = 1'b1;
                                state_d = TAIL;
                            end
                            default: begin
                                data_d = payData;
                                strb_d = 4'b1111;
                                if (bytes_q == 16'd4) state_d = TAIL;
                            end
                        endcase
                    end
                end
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            data_q     <= 32'h0;
            strb_q     <= 4'h0;
            rqst_q     <= 1'b0;
            last_q     <= 1'b0;
            bytes_q    <= 16'd0;
            rem3_q     <= 1'b0;
            errUnder_q <= 1'b0;
            errWc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            data_q     <= data_d;
            strb_q     <= strb_d;
            rqst_q     <= rqst_d;
            last_q     <= last_d;
            bytes_q    <= bytes_d;
            rem3_q     <= rem3_d;
            errUnder_q <= errUnder_d;
            errWc_q    <= errWc_d;
        end
    end

    assign pkt_ready_o        = ready_q;
    assign iface_write_data_o = data_q;
    assign iface_write_strb_o = strb_q;
    assign iface_write_rqst_o = rqst_q;
    assign iface_last_word_o  = last_q;
    assign err_underflow_o    = errUnder_q;
    assign err_wc_o           = errWc_q;

endmodule

// File: tb/tb_dsi_packet_assembler.sv
// Directed bench for dsi_packet_assembler: short/long packets, CRC tail layouts,
// stalls, payload underflow, word-count clamping and mid-packet reset.
module tb_dsi_packet_assembler;
    import dsi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        pktValid, pktReady, pktLong;
    logic [1:0]  pktVc;
    logic [5:0]  pktDt;
    logic [15:0] pktWc;
    logic [31:0] pldData;
    logic        pldValid, pldReady;
    logic [31:0] wrData;
    logic [3:0]  wrStrb;
    logic        wrRqst, lastWord, dataRqst;
    logic        errUnderflow, errWc;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic [15:0] crc7, crc6;

    always #5 clk = ~clk;

    dsi_packet_assembler #(
        .CRC_EN (1'b1),
        .WC_MAX (16'h00FF)
    ) dut (
        .clk_sys_i          (clk),
        .rst_i              (rst),
        .pkt_valid_i        (pktValid),
        .pkt_ready_o        (pktReady),
        .pkt_long_i         (pktLong),
        .pkt_vc_i           (pktVc),
        .pkt_data_type_i    (pktDt),
        .pkt_wc_i           (pktWc),
        .pld_data_i         (pldData),
        .pld_valid_i        (pldValid),
        .pld_ready_o        (pldReady),
        .iface_write_data_o (wrData),
        .iface_write_strb_o (wrStrb),
        .iface_write_rqst_o (wrRqst),
        .iface_last_word_o  (lastWord),
        .iface_data_rqst_i  (dataRqst),
        .err_underflow_o    (errUnderflow),
        .err_wc_o           (errWc)
    );

    // Bit-serial reflected CCITT reference over the first n bytes (byte i at [8i+:8]).
    function automatic logic [15:0] crcRef(input logic [63:0] bytes, input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ bytes[8*i + b];
                c  = c >> 1;
                if (fb) c = c ^ 16'h8408;
            end
        end
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic isLong, input logic [5:0] dt, input logic [15:0] wc);
        pktValid = valid;
        pktLong  = isLong;
        pktVc    = 2'd0;
        pktDt    = dt;
        pktWc    = wc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReady(input string tag);
        int budget;
        budget = 0;
        while (pktReady !== 1'b1 && budget < 20) begin
            step();
            budget++;
        end
        checkOutput(tag, 32'(pktReady), 32'h1);
    endtask

    initial begin
        crc7 = crcRef(64'h0077665544332211, 7);
        crc6 = crcRef(64'h00000000DDCCBBAA, 6);

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 6'h00, 16'h0000);
        pldData  = 32'h0;
        pldValid = 1'b0;
        dataRqst = 1'b0;

        #12;
        checkOutput("reset ready", 32'(pktReady), 32'h0);
        checkOutput("reset data", wrData, 32'h0);
        checkOutput("reset strb/rqst/last", {26'h0, wrStrb, wrRqst, lastWord}, 32'h0);
        checkOutput("reset errors", {30'h0, errUnderflow, errWc}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        checkOutput("ready after reset", 32'(pktReady), 32'h1);

        // Short packet 0x05 / 0x0011
        applyStimulus(1'b1, 1'b0, DT_DCS_SHORT_WR0, 16'h0011);
        step();
        pktValid = 1'b0;
        checkOutput("short1 header", wrData, 32'h36001105);
        checkOutput("short1 strb", 32'(wrStrb), 32'hF);
        checkOutput("short1 rqst+last", {30'h0, wrRqst, lastWord}, 32'h3);
        checkOutput("short1 busy", 32'(pktReady), 32'h0);
        dataRqst = 1'b1;
        step();
        dataRqst = 1'b0;
        checkOutput("short1 finish data", wrData, 32'h0);
        checkOutput("short1 finish strb/last", {27'h0, wrStrb, lastWord}, 32'h0);
        checkOutput("short1 ready again", 32'(pktReady), 32'h1);

        // Short packet 0x0029, next request held valid throughout
        applyStimulus(1'b1, 1'b0, DT_DCS_SHORT_WR0, 16'h0029);
        step();
        checkOutput("short2 header", wrData, 32'h1C002905);
        pktWc = 16'h0011;
        step();
        checkOutput("short2 rqst pulse ends", 32'(wrRqst), 32'h0);
        checkOutput("short2 word held", wrData, 32'h1C002905);
        checkOutput("short2 held req blocked", 32'(pktReady), 32'h0);
        dataRqst = 1'b1;
        step();
        dataRqst = 1'b0;
        checkOutput("short2 finish", wrData, 32'h0);
        checkOutput("short2 ready", 32'(pktReady), 32'h1);
        step();
        pktValid = 1'b0;
        checkOutput("short3 header", wrData, 32'h36001105);
        checkOutput("short3 rqst", 32'(wrRqst), 32'h1);
        dataRqst = 1'b1;
        step();
        dataRqst = 1'b0;
        checkOutput("short3 ready", 32'(pktReady), 32'h1);

        // Long packet, WC=0
        applyStimulus(1'b1, 1'b1, DT_DCS_LONG_WR, 16'd0);
        step();
        pktValid = 1'b0;
        checkOutput("wc0 header", wrData, 32'h0F000039);
        checkOutput("wc0 header last", 32'(lastWord), 32'h0);
        dataRqst = 1'b1;
        #1;
        checkOutput("wc0 no pld_ready", 32'(pldReady), 32'h0);
        step();
        checkOutput("wc0 crc word", wrData, 32'h0000FFFF);
        checkOutput("wc0 crc strb/last", {27'h0, wrStrb, lastWord}, {27'h0, 4'b0011, 1'b1});
        step();
        dataRqst = 1'b0;
        checkOutput("wc0 ready", 32'(pktReady), 32'h1);

        // Long packet, WC=7 (three bytes in final payload word, CRC split)
        applyStimulus(1'b1, 1'b1, DT_DCS_LONG_WR, 16'd7);
        step();
        pktValid = 1'b0;
        checkOutput("wc7 header", wrData, 32'h2A000739);
        pldData  = 32'h44332211;
        pldValid = 1'b1;
        dataRqst = 1'b1;
        #1;
        checkOutput("wc7 pld_ready", 32'(pldReady), 32'h1);
        step();
        checkOutput("wc7 word1", wrData, 32'h44332211);
        checkOutput("wc7 word1 strb", 32'(wrStrb), 32'hF);
        pldData = 32'h00776655;
        step();
        checkOutput("wc7 word2", wrData, {crc7[7:0], 24'h776655});
        checkOutput("wc7 word2 strb/last", {27'h0, wrStrb, lastWord}, {27'h0, 4'hF, 1'b0});
        pldValid = 1'b0;
        step();
        checkOutput("wc7 tail", wrData, {24'h0, crc7[15:8]});
        checkOutput("wc7 tail strb/last", {27'h0, wrStrb, lastWord}, {27'h0, 4'b0001, 1'b1});
        checkOutput("wc7 no underflow", 32'(errUnderflow), 32'h0);
        step();
        dataRqst = 1'b0;
        checkOutput("wc7 finish", wrData, 32'h0);
        checkOutput("wc7 ready", 32'(pktReady), 32'h1);

        // Long packet, WC=6 with stall and payload underflow
        applyStimulus(1'b1, 1'b1, DT_DCS_LONG_WR, 16'd6);
        step();
        pktValid = 1'b0;
        checkOutput("wc6 header", wrData, 32'h30000639);
        pldData  = 32'hDDCCBBAA;
        pldValid = 1'b1;
        dataRqst = 1'b1;
        step();
        dataRqst = 1'b0;
        pldValid = 1'b0;
        checkOutput("wc6 word1", wrData, 32'hDDCCBBAA);
        repeat (5) step();
        checkOutput("wc6 stall data", wrData, 32'hDDCCBBAA);
        checkOutput("wc6 stall strb/last", {27'h0, wrStrb, lastWord}, {27'h0, 4'hF, 1'b0});
        dataRqst = 1'b1;
        #1;
        checkOutput("wc6 pld_ready", 32'(pldReady), 32'h1);
        step();
        checkOutput("wc6 word2", wrData, {crc6, 16'h0000});
        checkOutput("wc6 word2 strb/last", {27'h0, wrStrb, lastWord}, {27'h0, 4'hF, 1'b1});
        checkOutput("wc6 underflow", 32'(errUnderflow), 32'h1);
        step();
        dataRqst = 1'b0;
        checkOutput("wc6 ready", 32'(pktReady), 32'h1);
        checkOutput("underflow sticky", 32'(errUnderflow), 32'h1);

        // Oversized word count, then reset mid-payload
        applyStimulus(1'b1, 1'b1, DT_DCS_LONG_WR, 16'h0100);
        step();
        pktValid = 1'b0;
        checkOutput("wcmax header", wrData, 32'h0600FF39);
        checkOutput("wcmax err_wc", 32'(errWc), 32'h1);
        pldData  = 32'h03020100;
        pldValid = 1'b1;
        dataRqst = 1'b1;
        step();
        checkOutput("wcmax word1", wrData, 32'h03020100);
        pldData = 32'h07060504;
        step();
        checkOutput("wcmax word2", wrData, 32'h07060504);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("abort data", wrData, 32'h0);
        checkOutput("abort strb/rqst/last", {26'h0, wrStrb, wrRqst, lastWord}, 32'h0);
        checkOutput("abort errors cleared", {30'h0, errUnderflow, errWc}, 32'h0);
        checkOutput("abort ready", 32'(pktReady), 32'h0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        dataRqst = 1'b0;
        pldValid = 1'b0;
        waitReady("post-abort ready");
        applyStimulus(1'b1, 1'b0, DT_DCS_SHORT_WR0, 16'h0011);
        step();
        pktValid = 1'b0;
        checkOutput("post-abort header", wrData, 32'h36001105);
        dataRqst = 1'b1;
        step();
        dataRqst = 1'b0;
        checkOutput("post-abort finish", wrData, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dsi_packet_assembler.md
Name: dsi_packet_assembler

Overview:
- Builds DSI short and long packets in the clk_sys domain and streams them as 32-bit words into dsi_lanes_controller through the iface_* word interface.
- For each packet it generates the 4-byte header (DI, WC/data, ECC) and packs the payload bytes.
- Long packets get a CRC16 checksum appended.
- The block sits directly upstream of the lanes controller; the packet/command scheduler feeds it.

Parameters:
- CRC_EN, 1, 1 = compute payload CRC16; 0 = send checksum 0x0000.
- WC_MAX, 16'hFFFF, largest accepted long-packet word count; larger requests set err_wc and are truncated to WC_MAX.

Ports:
- clk_sys  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pkt_valid  in  1  packet request valid
- pkt_ready  out  1  assembler idle, request accepted when valid&ready
- pkt_long  in  1  1 = long packet, 0 = short
- pkt_vc  in  2  virtual channel
- pkt_data_type  in  6  DSI data type
- pkt_wc  in  16  long: byte count; short: {data1,data0}
- pld_data  in  32  payload bytes, byte0 in [7:0], little-endian
- pld_valid  in  1  payload word available
- pld_ready  out  1  payload word consumed this cycle
- iface_write_data  out  32  word to lanes controller
- iface_write_strb  out  4  valid bytes of iface_write_data
- iface_write_rqst  out  1  one-cycle pulse: first word of a packet presented
- iface_last_word  out  1  current word is the packet's final word
- iface_data_rqst  in  1  lanes controller consumed current word, wants next
- err_underflow  out  1  sticky; payload not available when needed
- err_wc  out  1  sticky; pkt_wc > WC_MAX

Behaviour:
- Reset: all outputs 0, state IDLE; pkt_ready goes to 1 on the first cycle after reset. Sticky errors clear only on rst.
- States: IDLE, HEAD, PAYLOAD, TAIL. All iface_* outputs are registered.
- IDLE: pkt_ready=1. On pkt_valid, the next edge does all of the following:
  - latches the request;
  - drives the header word {ECC, WC[15:8], WC[7:0], DI}, with DI={vc,dt};
  - sets strb 4'hF and iface_write_rqst=1 for exactly one cycle;
  - sets iface_last_word=~pkt_long.
  - Then goes to HEAD.
- Word advance rule: an edge with iface_data_rqst=1 loads the next word, or finishes the packet if iface_last_word=1. Without iface_data_rqst the word holds indefinitely.
- Finish: outputs go to data=0, strb=0, last=0; state goes to IDLE; pkt_ready=1 the following cycle.
- Short packet: a single word with last=1, so it finishes on the first data_rqst.
- Long packet: N=ceil(WC/4) payload words; R=WC%4. The final payload word carries R bytes (4 if R=0) and the CRC starts right after them.
  - WC=0: word1=CRC, strb 0011, last.
  - R=0: payload words strb F, then tail word {16'h0,CRC} with strb 0011 and last.
  - R=1: final payload word {CRC,byte}, strb 0111, last.
  - R=2: final payload word {CRC,2 bytes}, strb 1111, last.
  - R=3: final payload word {CRC[7:0],3 bytes}, strb 1111; then tail {24'h0,CRC[15:8]}, strb 0001, last.
- pld_ready=1 combinationally on cycles where a payload word is loaded (data_rqst=1 with a payload word next, or the header advance). If pld_valid=0 at that moment:
  - err_underflow sets;
  - word 0 is sent with the required strb;
  - the CRC is still updated over the sent bytes.
- CRC: CRC-16-CCITT, reflected poly 0x8408, init 0xFFFF, LSB-first per byte, over payload bytes only (masked by strb).
  - The CRC must include the bytes of the same word it is packed into, so the combinational per-byte chain covers up to 4 bytes.
- ECC: DSI 6-bit Hamming over the 24 header bits; bits [7:6]=0.
- rst mid-packet aborts immediately. The lanes controller sees iface_* drop to 0 asynchronously.

Decomposition:
- Package dsi_pkg:
  - state enum;
  - function dsi_ecc(24b)->8b;
  - function crc16_byte(crc,byte);
  - data-type constants (DT_DCS_SHORT_WR0=6'h05, DT_DCS_LONG_WR=6'h39).
- Sub-module dsi_crc16: 4-byte strobed combinational update plus a registered state with init/clear.

Test Plan:
- Short DI 0x05 (vc0), wc 16'h0011 -> word 0x36001105, strb F, rqst pulse plus last together; pkt_ready returns after 1 data_rqst.
- Short 0x05/0x0029 -> 0x1C002905; a second pkt_valid held during the packet is not accepted until the finish.
- Long 0x39, WC=0 -> header then 0x0000FFFF, strb 0011, last.
- Long WC=7, payload 0x44332211, 0x00776655 -> strbs F, F (R=3 path: CRC low byte in the last word), then a tail word with strb 0001. CRC is compared against a bench reference model.
- Long WC=6, data_rqst withheld 5 cycles mid-packet -> outputs stable; pld_valid low at the second word -> err_underflow=1, zero bytes sent.
- pkt_wc=16'h0100 with WC_MAX=16'h00FF -> err_wc=1, 0xFF bytes sent; rst asserted mid-payload -> all outputs 0 immediately, then a clean IDLE.
